serial_tx_arbiter: RTL and testbench

SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

---
 rtl/serial_tx_pkg.sv | 53 +++++
 rtl/serial_tx_holdbuf.sv | 60 ++++++
 rtl/serial_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_pkg
//  Brief    : Shared types and constants for the two-requester serial
//             transmit arbiter (FSM encoding, requester count, defaults,
//             arbitration helper).
//  Revision : 1.0  initial release
// ============================================================================
package serial_tx_pkg;

    // Number of requesters sharing the serial channel.
    localparam int NUM_REQ           = 2;
    // Byte width carried through the arbiter.
    localparam int DATA_W            = 8;
    // Default maximum bytes per locked burst.
    localparam int DEFAULT_MAX_BURST = 16;

    // Channel FSM: pick an owner, present one byte, then a one-cycle gap
    // so the transmitter's busy flag has time to rise.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

    // Arbitration decision: returns {found, index}.
    // Locked: only the lock owner may win. Unlocked with both pending:
    // alternate away from the previous grant. Otherwise the single
    // pending requester wins.
    function automatic logic [1:0] arb_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic               prev_grant,
        input logic               locked,
        input logic               lock_idx
    );
        logic [1:0] result;
        result = 2'b00;
        if (locked) begin
            if (valid[lock_idx]) begin
                result = {1'b1, lock_idx};
            end
        end else if (valid == 2'b11) begin
            result = {1'b1, ~prev_grant};
        end else if (valid[0]) begin
            result = 2'b10;
        end else if (valid[1]) begin
            result = 2'b11;
        end
        return result;
    endfunction

endpackage : serial_tx_pkg
`default_nettype wire

// File: rtl/serial_tx_holdbuf.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_holdbuf
//  Brief    : One-entry holding buffer for a single requester. Captures a
//             byte when empty, reports busy while full, and flags strobes
//             that arrive while full (they are dropped).
//  Revision : 1.0  initial release
// ============================================================================
module serial_tx_holdbuf
    import serial_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              new_i,
    input  logic              last_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              valid_o,
    output logic              overflow_o
);

    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic              valid_q;
    logic              ovf_q;
    logic              capture_d;

    // A byte is taken only into an empty entry. The clear from the arbiter
    // always targets a full entry, so a strobe in the clearing cycle sees
    // the entry still full and is dropped with an overflow pulse.
    assign capture_d = new_i && !valid_q;

    // Entry storage, occupancy flag and one-cycle overflow pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= new_i && valid_q;
            if (clear_i) begin
                valid_q <= 1'b0;
            end else if (capture_d) begin
                valid_q <= 1'b1;
                data_q  <= data_i;
                last_q  <= last_i;
            end
        end
    end

    assign data_o     = data_q;
    assign last_o     = last_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;

endmodule : serial_tx_holdbuf
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_arbiter
//  Brief    : Merges byte streams from two requesters onto one serial
//             transmitter. Alternating arbitration, packet lock until the
//             last byte or MAX_BURST bytes, transmitter back-pressure.
//  Revision : 1.0  initial release
// ============================================================================
module serial_tx_arbiter
    import serial_tx_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_new,
    input  logic              req0_last,
    output logic              req0_busy,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_new,
    input  logic              req1_last,
    output logic              req1_busy,
    output logic [DATA_W-1:0] tx_data,
    output logic              new_tx_data,
    input  logic              tx_busy,
    output logic [1:0]        overflow,
    output logic              grant
);

    // Counter holds 0..MAX_BURST without wrapping.
    localparam int                CNT_W       = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]  c_MAX_BURST = CNT_W'(MAX_BURST);

    // Per-requester buffer connections.
    logic [DATA_W-1:0]  w_req_data [NUM_REQ];
    logic [NUM_REQ-1:0] w_req_new;
    logic [NUM_REQ-1:0] w_req_last;
    logic [DATA_W-1:0]  w_buf_data [NUM_REQ];
    logic [NUM_REQ-1:0] w_buf_last;
    logic [NUM_REQ-1:0] w_buf_valid;
    logic [NUM_REQ-1:0] w_buf_ovf;
    logic [NUM_REQ-1:0] w_buf_clear;

    // Channel state.
    tx_state_e          state_q;
    logic               grant_q;
    logic               locked_q;
    logic               lock_idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [DATA_W-1:0]  tx_data_q;

    logic [1:0]         w_pick;
    logic               w_strobe;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_sel_last;

    assign w_req_data[0] = req0_data;
    assign w_req_data[1] = req1_data;
    assign w_req_new     = {req1_new,  req0_new};
    assign w_req_last    = {req1_last, req0_last};

    // One holding buffer per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            serial_tx_holdbuf u_holdbuf (
                .clk        (clk),
                .rst        (rst),
                .data_i     (w_req_data[gi]),
                .new_i      (w_req_new[gi]),
                .last_i     (w_req_last[gi]),
                .clear_i    (w_buf_clear[gi]),
                .data_o     (w_buf_data[gi]),
                .last_o     (w_buf_last[gi]),
                .valid_o    (w_buf_valid[gi]),
                .overflow_o (w_buf_ovf[gi])
            );
            // The granted buffer empties on the cycle its byte is handed over.
            assign w_buf_clear[gi] = w_strobe && (grant_q == 1'(gi));
        end
    endgenerate

    assign w_pick     = arb_pick(w_buf_valid, grant_q, locked_q, lock_idx_q);
    assign w_sel_data = w_buf_data[grant_q];
    assign w_sel_last = w_buf_last[grant_q];
    assign cnt_d      = cnt_q + CNT_W'(1);

    // The strobe is qualified by the transmitter's busy flag in the same
    // cycle; this keeps the capture-to-strobe latency at two cycles while
    // never pushing a byte into a busy transmitter.
    assign w_strobe   = (state_q == ST_SEND) && !tx_busy;

    // Channel FSM: arbitration, byte hand-over, lock and burst accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b1;
            locked_q   <= 1'b0;
            lock_idx_q <= 1'b0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_pick[1]) begin
                        grant_q <= w_pick[0];
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_data_q <= w_sel_data;
                        state_q   <= ST_GAP;
                        // End of packet or burst budget spent: open the
                        // channel to the other requester again.
                        if (w_sel_last || (cnt_d == c_MAX_BURST)) begin
                            locked_q <= 1'b0;
                            cnt_q    <= '0;
                        end else begin
                            locked_q   <= 1'b1;
                            lock_idx_q <= grant_q;
                            cnt_q      <= cnt_d;
                        end
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // tx_data shows the outgoing byte during the strobe and otherwise holds
    // the most recently sent byte.
    assign new_tx_data = w_strobe;
    assign tx_data     = w_strobe ? w_sel_data : tx_data_q;
    assign grant       = grant_q;
    assign overflow    = w_buf_ovf;
    assign req0_busy   = w_buf_valid[0];
    assign req1_busy   = w_buf_valid[1];

endmodule : serial_tx_arbiter
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx_arbiter
//  Brief    : Self-checking bench for serial_tx_arbiter. A timeline-based
//             reference model predicts every byte hand-over; a monitor pops
//             expected bytes from a scoreboard queue on each strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_tx_arbiter;

    localparam int MB = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       req;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req0_data, req1_data;
    logic       req0_new, req0_last, req1_new, req1_last;
    logic       req0_busy, req1_busy;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;
    logic [1:0] overflow;
    logic       grant;

    serial_tx_arbiter #(.MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_data   (req0_data),
        .req0_new    (req0_new),
        .req0_last   (req0_last),
        .req0_busy   (req0_busy),
        .req1_data   (req1_data),
        .req1_new    (req1_new),
        .req1_last   (req1_last),
        .req1_busy   (req1_busy),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .overflow    (overflow),
        .grant       (grant)
    );

    always #10 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    exp_t       exp_q[$];
    logic [7:0] sent_log[$];
    logic [8:0] s0[$], s1[$];   // {last, data} byte streams per requester
    int         ovf0_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: buffers as plain flags, channel availability as a
    // timestamp, lock as an owner plus byte count.
    // ------------------------------------------------------------------
    int         cyc = 0;
    bit  [1:0]  m_valid;
    logic [7:0] m_data [2];
    bit  [1:0]  m_last;
    bit  [1:0]  m_ovf;
    bit         m_grant;
    bit         m_locked;
    int         m_lock_req;
    int         m_cnt;
    bit         m_pending;
    int         m_pend_req;
    int         m_free_at;
    logic [7:0] m_last_sent;

    task automatic model_reset();
        m_valid = '0; m_last = '0; m_ovf = '0;
        m_grant = 1'b1; m_locked = 1'b0; m_lock_req = 0; m_cnt = 0;
        m_pending = 1'b0; m_pend_req = 0; m_free_at = 0; m_last_sent = 8'h00;
        exp_q.delete();
    endtask

    always @(negedge clk) begin : predictor
        bit         strobe;
        bit  [1:0]  start_valid;
        bit  [1:0]  nov;
        bit  [1:0]  news;
        logic [7:0] din [2];
        bit  [1:0]  lin;
        int         k;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            strobe = m_pending && !tx_busy;
            check("req0_busy", 32'(req0_busy), 32'(m_valid[0]));
            check("req1_busy", 32'(req1_busy), 32'(m_valid[1]));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("grant", 32'(grant), 32'(m_grant));
            check("new_tx_data", 32'(new_tx_data), 32'(strobe));
            if (!strobe) check("tx_data_hold", 32'(tx_data), 32'(m_last_sent));

            start_valid = m_valid;
            if (strobe) begin
                k = m_pend_req;
                m_last_sent = m_data[k];
                if (m_last[k]) begin
                    m_locked = 1'b0; m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == MB) begin
                        m_locked = 1'b0; m_cnt = 0;
                    end else begin
                        m_locked = 1'b1; m_lock_req = k;
                    end
                end
                m_pending = 1'b0;
                m_free_at = cyc + 2;
            end else if (!m_pending && cyc >= m_free_at) begin
                k = -1;
                if (m_locked) begin
                    if (m_valid[m_lock_req]) k = m_lock_req;
                end else if (m_valid == 2'b11) begin
                    k = m_grant ? 0 : 1;
                end else if (m_valid[0]) begin
                    k = 0;
                end else if (m_valid[1]) begin
                    k = 1;
                end
                if (k >= 0) begin
                    m_pending  = 1'b1;
                    m_pend_req = k;
                    m_grant    = k[0];
                    exp_q.push_back('{data: m_data[k], req: k[0]});
                end
            end

            news   = {req1_new, req0_new};
            din[0] = req0_data; din[1] = req1_data;
            lin    = {req1_last, req0_last};
            nov    = '0;
            for (int i = 0; i < 2; i++) begin
                if (news[i]) begin
                    if (start_valid[i]) nov[i] = 1'b1;
                    else begin
                        m_valid[i] = 1'b1; m_data[i] = din[i]; m_last[i] = lin[i];
                    end
                end
            end
            if (strobe) m_valid[m_pend_req] = 1'b0;
            m_ovf = nov;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares each presented byte against the scoreboard.
    // ------------------------------------------------------------------
    int mcyc = 0;
    int last_strobe = -100;
    always @(negedge clk) begin : monitor
        exp_t e;
        mcyc++;
        if (rst) begin
            last_strobe = -100;
        end else begin
            if (overflow[0]) ovf0_count++;
            if (new_tx_data) begin
                check("strobe_spacing_ge3", 32'(mcyc - last_strobe >= 3), 32'd1);
                last_strobe = mcyc;
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_strobe: got 0x%0h expected no byte", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("tx_grant", 32'(grant), 32'(e.req));
                end
                sent_log.push_back(tx_data);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_new = 1'b0; req1_new = 1'b0;
        req0_last = 1'b0; req1_last = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic clear_log();
        sent_log.delete();
        ovf0_count = 0;
    endtask

    task automatic log_expect(input int idx, input logic [7:0] v);
        if (idx < sent_log.size()) begin
            check($sformatf("log[%0d]", idx), 32'(sent_log[idx]), 32'(v));
        end else begin
            n_checks++; n_errors++;
            $display("FAIL log[%0d]: got nothing expected 0x%0h", idx, v);
        end
    endtask

    // Feed s0/s1 to the requesters whenever they are not busy.
    task automatic run_streams(input int d0, input int d1, input int max_cyc, input bit chk_drain);
        tx_busy = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            req0_new = 1'b0; req1_new = 1'b0;
            if (c >= d0 && s0.size() > 0 && !req0_busy) begin
                {req0_last, req0_data} = s0.pop_front();
                req0_new = 1'b1;
            end
            if (c >= d1 && s1.size() > 0 && !req1_busy) begin
                {req1_last, req1_data} = s1.pop_front();
                req1_new = 1'b1;
            end
            step();
        end
        idle_inputs();
        if (chk_drain) check("streams_drained", 32'(s0.size() + s1.size()), 32'd0);
        s0.delete(); s1.delete();
    endtask

    initial begin
        rst = 1'b1;
        tx_busy = 1'b0;
        idle_inputs();
        step(); step();
        // Reset values.
        check("rst_new_tx_data", 32'(new_tx_data), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'({req1_busy, req0_busy}), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_grant", 32'(grant), 32'd1);
        rst = 1'b0;

        // Contention: requester 0 wins first after reset.
        clear_log();
        s0.push_back({1'b1, 8'h10});
        s1.push_back({1'b1, 8'h20});
        run_streams(0, 0, 20, 1'b1);
        check("contention_n", 32'(sent_log.size()), 32'd2);
        log_expect(0, 8'h10);
        log_expect(1, 8'h20);

        // Single byte.
        clear_log();
        s0.push_back({1'b1, 8'h41});
        run_streams(0, 0, 12, 1'b1);
        check("single_n", 32'(sent_log.size()), 32'd1);
        log_expect(0, 8'h41);

        // Packet lock holds off the other requester.
        apply_reset();
        clear_log();
        s1.push_back({1'b0, 8'hA0});
        s1.push_back({1'b0, 8'hA1});
        s1.push_back({1'b1, 8'hA2});
        s0.push_back({1'b1, 8'h55});
        run_streams(1, 0, 40, 1'b1);
        check("lock_n", 32'(sent_log.size()), 32'd4);
        log_expect(0, 8'hA0);
        log_expect(1, 8'hA1);
        log_expect(2, 8'hA2);
        log_expect(3, 8'h55);

        // Burst limit forces release after MB bytes.
        apply_reset();
        clear_log();
        for (int i = 0; i < 20; i++) s0.push_back({1'b0, 8'(i)});
        s1.push_back({1'b1, 8'h77});
        run_streams(0, 1, 200, 1'b1);
        check("burst_n", 32'(sent_log.size()), 32'd21);
        log_expect(15, 8'd15);
        log_expect(16, 8'h77);
        log_expect(17, 8'd16);

        // Back-pressure and overflow.
        apply_reset();
        clear_log();
        tx_busy = 1'b1;
        req0_new = 1'b1; req0_last = 1'b1; req0_data = 8'h01;
        step();
        req0_data = 8'h02;
        step();
        idle_inputs();
        repeat (8) step();
        tx_busy = 1'b0;
        repeat (6) step();
        check("bp_n", 32'(sent_log.size()), 32'd1);
        log_expect(0, 8'h01);
        check("bp_ovf0_pulses", 32'(ovf0_count), 32'd1);

        // Reset in the middle of a locked burst.
        apply_reset();
        clear_log();
        s1.push_back({1'b0, 8'hB0});
        s1.push_back({1'b0, 8'hB1});
        s1.push_back({1'b0, 8'hB2});
        run_streams(0, 0, 7, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_new_tx_data", 32'(new_tx_data), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_busy", 32'({req1_busy, req0_busy}), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd1);
        step();
        rst = 1'b0;
        clear_log();
        s0.push_back({1'b1, 8'h5A});
        s1.push_back({1'b1, 8'h6B});
        run_streams(0, 0, 20, 1'b1);
        check("post_rst_n", 32'(sent_log.size()), 32'd2);
        log_expect(0, 8'h5A);
        log_expect(1, 8'h6B);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            req0_new  = ($urandom_range(0, 2) == 0);
            req1_new  = ($urandom_range(0, 2) == 0);
            req0_data = 8'($urandom);
            req1_data = 8'($urandom);
            req0_last = (c < 2000) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            req1_last = (c < 2000) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) tx_busy = ~tx_busy;
            step();
        end
        idle_inputs();
        tx_busy = 1'b0;
        repeat (20) step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_serial_tx_arbiter
`default_nettype wire
